// File: rtl/deserializer_pkg.sv
// ---------------------------------------------------------------------------
// deser_pkg -- shared types and constants for the serial byte receiver.
//   deser_state_t : receiver FSM states (IDLE = no partial byte, RECV = mid-byte)
//   DESER_DATA_W  : default bits per byte
//   DESER_TIMEOUT : default idle timeout in system clocks
//   frame_bits()  : serial bits per frame (data bits, plus one parity bit when
//                   DESERIALIZER_PARITY_EN is defined)
// Optional feature macro: DESERIALIZER_PARITY_EN
// ---------------------------------------------------------------------------
package deser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_t;

  localparam int DESER_DATA_W  = 8;
  localparam int DESER_TIMEOUT = 1024;

  function automatic int frame_bits(input int data_w);
`ifdef DESERIALIZER_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// ---------------------------------------------------------------------------
// deserializer_if -- parallel-side bus of the serial byte receiver.
//   par_data   : received byte, stable while valid=1
//   valid      : byte available
//   ready      : downstream accepts (transfer when valid & ready)
//   overrun    : one-cycle pulse, completed byte dropped
//   frame_err  : one-cycle pulse, partial byte discarded by timeout
//   busy       : partial byte in progress
//   parity_err : parity check result for par_data (DESERIALIZER_PARITY_EN only)
// Modports: master (receiver side), slave (downstream consumer side).
// Optional feature macro: DESERIALIZER_PARITY_EN
// ---------------------------------------------------------------------------
interface deserializer_if
  import deser_pkg::*;
#(
  parameter int DATA_W = DESER_DATA_W
) ();

  logic [DATA_W-1:0] par_data;
  logic              valid;
  logic              ready;
  logic              overrun;
  logic              frame_err;
  logic              busy;

`ifdef DESERIALIZER_PARITY_EN
  logic              parity_err;

  modport master (
    output par_data, valid, overrun, frame_err, busy, parity_err,
    input  ready
  );

  modport slave (
    input  par_data, valid, overrun, frame_err, busy, parity_err,
    output ready
  );
`else
  modport master (
    output par_data, valid, overrun, frame_err, busy,
    input  ready
  );

  modport slave (
    input  par_data, valid, overrun, frame_err, busy,
    output ready
  );
`endif

endinterface

// File: rtl/deserializer_edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync -- brings ser_clock / ser_data into the system clock domain and
// flags the rising edges of the synchronised serial clock.
//   clock, reset : system clock, asynchronous active-high reset
//   ser_clock    : raw serial bit clock (asynchronous)
//   ser_data     : raw serial data
//   sedge        : one-cycle pulse per serial rising edge (registered)
//   sdata        : synchronised data sampled at that same edge (registered)
// Both paths go through the same number of flops so sdata lines up with sedge.
// ---------------------------------------------------------------------------
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ser_clock,
  input  logic ser_data,
  output logic sedge,
  output logic sdata
);

  // Index 0 is the first flop of each chain.
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_prev_r;
  logic                   sedge_r;
  logic                   sdata_r;

  // Synchroniser chains, edge detector and registered edge/data outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_r <= '0;
      dat_sync_r <= '0;
      clk_prev_r <= 1'b0;
      sedge_r    <= 1'b0;
      sdata_r    <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ser_clock};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ser_data};
      clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
      sedge_r    <= clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
      sdata_r    <= dat_sync_r[SYNC_STAGES-1];
    end
  end

  assign sedge = sedge_r;
  assign sdata = sdata_r;

endmodule

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer -- rebuilds parallel bytes from an LSB-first serial stream.
//   clock, reset : system clock, asynchronous active-high reset
//   ser_clock    : serial bit clock from the upstream serializer (async)
//   ser_data     : serial data, valid at the rising edge of ser_clock
//   bus          : deserializer_if.master (par_data, valid, ready, overrun,
//                  frame_err, busy, parity_err when enabled)
// Parameters: DATA_W, TIMEOUT (>= 4), SYNC_STAGES (>= 2).
// Optional feature macro: DESERIALIZER_PARITY_EN -- an even-parity bit follows
// the data bits; parity_err reports a mismatch, the byte is still delivered.
// ---------------------------------------------------------------------------
module deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W      = DESER_DATA_W,
  parameter int TIMEOUT     = DESER_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ser_clock,
  input  logic           ser_data,
  deserializer_if.master bus
);

  localparam int FRAME_W = frame_bits(DATA_W);
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int TMO_W   = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

`ifdef DESERIALIZER_PARITY_EN
  // Even parity over data + parity bit: a nonzero XOR means a bad frame.
  function automatic logic parity_bad(input logic [FRAME_W-1:0] frame);
    return ^frame;
  endfunction
`endif

  logic sedge_s;
  logic sdata_s;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock     (clock),
    .reset     (reset),
    .ser_clock (ser_clock),
    .ser_data  (ser_data),
    .sedge     (sedge_s),
    .sdata     (sdata_s)
  );

  deser_state_t       state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  // Bits received so far; the newest bit sits at the top, bit 0 drifts down
  // to index 0 by the time the final bit arrives.
  logic [FRAME_W-2:0] shift_r;
  logic [DATA_W-1:0]  par_data_r;
  logic               valid_r;
  logic               overrun_r;
  logic               frame_err_r;
  logic               busy_r;
`ifdef DESERIALIZER_PARITY_EN
  logic               parity_err_r;
`endif

  logic [FRAME_W-1:0] frame_s;
  logic               accept_s;

  // Frame as it stands once the current bit is shifted in, and whether the
  // output register can take a new byte this cycle.
  always_comb begin
    frame_s  = {sdata_s, shift_r};
    accept_s = ~valid_r | bus.ready;
  end

  // Receiver FSM, timeout counter and registered output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      shift_r      <= '0;
      par_data_r   <= '0;
      valid_r      <= 1'b0;
      overrun_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      // A completing byte below may re-set valid in the same cycle.
      if (valid_r && bus.ready) begin
        valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          tmo_cnt_r <= '0;
          if (sedge_s) begin
            shift_r   <= frame_s[FRAME_W-1:1];
            bit_cnt_r <= CNT_W'(1);
            busy_r    <= 1'b1;
            state_r   <= RECV;
          end else begin
            busy_r    <= 1'b0;
          end
        end

        RECV: begin
          // A serial edge takes priority over an expiring timeout.
          if (sedge_s) begin
            shift_r   <= frame_s[FRAME_W-1:1];
            tmo_cnt_r <= '0;
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              busy_r    <= 1'b0;
              state_r   <= IDLE;
              if (accept_s) begin
                par_data_r   <= frame_s[DATA_W-1:0];
                valid_r      <= 1'b1;
`ifdef DESERIALIZER_PARITY_EN
                parity_err_r <= parity_bad(frame_s);
`endif
              end else begin
                overrun_r    <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            bit_cnt_r   <= '0;
            tmo_cnt_r   <= '0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            // Only reached below TMO_LAST, so the counter cannot wrap.
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end

        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= '0;
          tmo_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.par_data   = par_data_r;
  assign bus.valid      = valid_r;
  assign bus.overrun    = overrun_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;
`ifdef DESERIALIZER_PARITY_EN
  assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer -- directed self-checking bench for deserializer.
// Serial clock period is 8 system clocks (4 low, 4 high); inputs change 1 ns
// after a rising system clock edge and outputs are sampled at that point too.
// Works with and without DESERIALIZER_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_deserializer;

`ifdef DESERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clock = 1'b0;
  logic reset;
  logic ser_clock;
  logic ser_data;

  int vectors     = 0;
  int miscompares = 0;
  int ovr_cnt     = 0;
  int fe_cnt      = 0;

  deserializer_if #(.DATA_W(8)) bus ();

  deserializer #(
    .DATA_W      (8),
    .TIMEOUT     (16),
    .SYNC_STAGES (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ser_clock (ser_clock),
    .ser_data  (ser_data),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.overrun)   ovr_cnt <= ovr_cnt + 1;
    if (bus.frame_err) fe_cnt  <= fe_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Data with even parity appended when parity is enabled.
  function automatic logic [8:0] mk_frame(input logic [7:0] b);
    return {^b, b};
  endfunction

  // Low half with data set up, then raise ser_clock and return immediately.
  task automatic send_bit(input logic b);
    ser_clock = 1'b0;
    ser_data  = b;
    repeat (4) tick();
    ser_clock = 1'b1;
  endtask

  // Full frame; returns 4 clocks after the final raw rising edge, which is
  // the cycle in which valid becomes visible.
  task automatic send_raw(input logic [8:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(f[i]);
      repeat (4) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(mk_frame(b), NB);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ser_clock = 1'b0;
    ser_data  = 1'b0;
    bus.ready = 1'b0;
    repeat (3) tick();
    vectors++; if (bus.par_data !== 8'h00) begin miscompares++; $display("FAIL reset_par_data: got %h want 00", bus.par_data); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_byte_delivery();
    logic [8:0] f;
    int ovr0;
    f    = mk_frame(8'hA5);
    ovr0 = ovr_cnt;
    bus.ready = 1'b1;
    for (int i = 0; i < NB - 1; i++) begin
      send_bit(f[i]);
      repeat (4) tick();
    end
    send_bit(f[NB-1]);
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++; if (bus.valid !== (k == 4)) begin miscompares++; $display("FAIL delivery_valid_t%0d: got %b want %b", k, bus.valid, (k == 4)); end
      if (k == 4) begin
        vectors++; if (bus.par_data !== 8'hA5) begin miscompares++; $display("FAIL delivery_data: got %h want a5", bus.par_data); end
      end
    end
    repeat (3) tick();
    vectors++; if (ovr_cnt !== ovr0) begin miscompares++; $display("FAIL delivery_overrun: got %0d pulses want 0", ovr_cnt - ovr0); end
  endtask

  task automatic test_overrun();
    int ovr0;
    ovr0 = ovr_cnt;
    bus.ready = 1'b0;
    send_byte(8'h3C);
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h3C) begin miscompares++; $display("FAIL overrun_first: got valid %b data %h want 1 3c", bus.valid, bus.par_data); end
    send_byte(8'hC3);
    vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_pulse: got %b want 1", bus.overrun); end
    tick();
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_pulse_end: got %b want 0", bus.overrun); end
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h3C) begin miscompares++; $display("FAIL overrun_hold: got valid %b data %h want 1 3c", bus.valid, bus.par_data); end
    vectors++; if (ovr_cnt - ovr0 !== 1) begin miscompares++; $display("FAIL overrun_count: got %0d want 1", ovr_cnt - ovr0); end
    bus.ready = 1'b1;
    tick();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL overrun_drain: got valid %b want 0", bus.valid); end
  endtask

  task automatic test_simultaneous_accept();
    logic [8:0] f;
    int ovr0;
    ovr0 = ovr_cnt;
    f    = mk_frame(8'h22);
    bus.ready = 1'b0;
    send_byte(8'h11);
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h11) begin miscompares++; $display("FAIL simul_first: got valid %b data %h want 1 11", bus.valid, bus.par_data); end
    for (int i = 0; i < NB - 1; i++) begin
      send_bit(f[i]);
      repeat (4) tick();
    end
    send_bit(f[NB-1]);
    repeat (3) tick();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h22) begin miscompares++; $display("FAIL simul_load: got valid %b data %h want 1 22", bus.valid, bus.par_data); end
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL simul_overrun: got %b want 0", bus.overrun); end
    tick();
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h22) begin miscompares++; $display("FAIL simul_hold: got valid %b data %h want 1 22", bus.valid, bus.par_data); end
    vectors++; if (ovr_cnt !== ovr0) begin miscompares++; $display("FAIL simul_ovr_count: got %0d want 0", ovr_cnt - ovr0); end
    bus.ready = 1'b1;
    tick();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL simul_drain: got %b want 0", bus.valid); end
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_cnt;
    bus.ready = 1'b1;
    send_bit(1'b1); repeat (4) tick();
    send_bit(1'b0); repeat (4) tick();
    send_bit(1'b1);
    // Third bit handled 4 clocks after its raw edge, then 16 idle clocks.
    repeat (19) tick();
    vectors++; if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL timeout_early: got fe %b busy %b want 0 1", bus.frame_err, bus.busy); end
    tick();
    vectors++; if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_fire: got fe %b busy %b want 1 0", bus.frame_err, bus.busy); end
    tick();
    vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse_end: got %b want 0", bus.frame_err); end
    vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL timeout_count: got %0d want 1", fe_cnt - fe0); end
    send_byte(8'h5A);
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h5A) begin miscompares++; $display("FAIL timeout_recover: got valid %b data %h want 1 5a", bus.valid, bus.par_data); end
    tick();
  endtask

  task automatic test_reset_mid_byte();
    int ovr0;
    int fe0;
    ovr0 = ovr_cnt;
    fe0  = fe_cnt;
    bus.ready = 1'b1;
    send_raw(9'h1FF, 5);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL midreset_busy_before: got %b want 1", bus.busy); end
    reset = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin miscompares++; $display("FAIL midreset_async: got busy %b valid %b want 0 0", bus.busy, bus.valid); end
    ser_clock = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    vectors++; if (ovr_cnt !== ovr0 || fe_cnt !== fe0) begin miscompares++; $display("FAIL midreset_pulses: got ovr %0d fe %0d want 0 0", ovr_cnt - ovr0, fe_cnt - fe0); end
    send_byte(8'hFF);
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'hFF) begin miscompares++; $display("FAIL midreset_recover: got valid %b data %h want 1 ff", bus.valid, bus.par_data); end
    tick();
  endtask

`ifdef DESERIALIZER_PARITY_EN
  task automatic test_parity();
    bus.ready = 1'b1;
    send_raw(9'h107, 9);
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h07 || bus.parity_err !== 1'b0) begin miscompares++; $display("FAIL parity_good: got valid %b data %h perr %b want 1 07 0", bus.valid, bus.par_data, bus.parity_err); end
    tick();
    send_raw(9'h007, 9);
    vectors++; if (bus.valid !== 1'b1 || bus.par_data !== 8'h07 || bus.parity_err !== 1'b1) begin miscompares++; $display("FAIL parity_bad: got valid %b data %h perr %b want 1 07 1", bus.valid, bus.par_data, bus.parity_err); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_byte_delivery();
    test_overrun();
    test_simultaneous_accept();
    test_timeout();
    test_reset_mid_byte();
`ifdef DESERIALIZER_PARITY_EN
    test_parity();
`endif
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
